// File: rtl/uart_stream_arb.sv
// uart_stream_arb
// Packet-locked round-robin arbiter that merges NUM_SRC byte streams into the
// single s_axis input of a UART transmitter. One bubble cycle is spent in IDLE
// per arbitration; while a packet is granted the datapath is a pure mux, so no
// beat is ever buffered, dropped or duplicated.
//
// Optional feature: define UART_STREAM_ARB_TIMEOUT_EN to compile in a stall
// watchdog that revokes a grant whose source has held valid low for
// TIMEOUT_CYCLES consecutive cycles mid-packet. Without the macro a stalled
// grant is held indefinitely and timeout_err is tied low.

module uart_stream_arb #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SRC        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] req_tdata,
  input  logic [NUM_SRC-1:0]            req_tvalid,
  input  logic [NUM_SRC-1:0]            req_tlast,
  output logic [NUM_SRC-1:0]            req_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          grant_valid,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic                          pkt_done,
  output logic                          timeout_err
);

  localparam int ID_W = $clog2(NUM_SRC);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ID_W-1:0]       grant_q;
  logic [ID_W-1:0]       grant_d;
  logic [ID_W-1:0]       last_q;
  logic [ID_W-1:0]       last_d;

  logic [ID_W-1:0]       rr_sel;
  logic                  rr_found;

  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  beat;
  logic                  stall_hit;

  // Mux the currently granted source onto a set of local signals.
  always_comb begin
    cur_valid = req_tvalid[grant_q];
    cur_last  = req_tlast[grant_q];
    cur_data  = req_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid source after last_q, wrapping at NUM_SRC.
  always_comb begin
    logic [ID_W:0] cand;
    rr_found = 1'b0;
    rr_sel   = last_q;
    cand     = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = {1'b0, last_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_SRC)) begin
        cand = cand - (ID_W+1)'(NUM_SRC);
      end
      if (!rr_found && req_tvalid[cand[ID_W-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = cand[ID_W-1:0];
      end
    end
  end

  // A beat moves only on a valid/ready handshake while a packet is granted.
  always_comb begin
    beat = (state_q == XFER) && cur_valid && m_axis_tready;
  end

`ifdef UART_STREAM_ARB_TIMEOUT_EN
  // Counter only ever reaches TIMEOUT_CYCLES-1 before the grant is revoked.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt_q;

  // The TIMEOUT_CYCLES-th consecutive cycle with the granted valid low.
  always_comb begin
    stall_hit = (state_q == XFER) && !cur_valid &&
                (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Count consecutive valid-low cycles of the granted source; a high valid
  // (even without ready) or a fresh grant restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (state_q != XFER) begin
      stall_cnt_q <= '0;
    end else if (cur_valid || stall_hit) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // FSM next-state, grant bookkeeping and the combinational stream datapath.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    req_tready    = '0;
    pkt_done      = 1'b0;
    timeout_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Bubble cycle: datapath closed while the next grant is chosen.
        if (rr_found) begin
          grant_d = rr_sel;
          state_d = XFER;
        end
      end
      XFER: begin
        m_axis_tdata        = cur_data;
        m_axis_tvalid       = cur_valid;
        req_tready[grant_q] = m_axis_tready;
        if (beat && cur_last) begin
          pkt_done = 1'b1;
          last_d   = grant_q;
          state_d  = IDLE;
        end else if (stall_hit) begin
          timeout_err = 1'b1;
          last_d      = grant_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers; last_q resets so that
  // source 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_valid = (state_q == XFER);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_uart_stream_arb.sv
// tb_uart_stream_arb
// Scoreboard bench for uart_stream_arb (NUM_SRC=4, DATA_WIDTH=8,
// TIMEOUT_CYCLES=8). Source traffic comes from per-source beat memories;
// expected output beats (source, byte, cycle gap) are queued when stimulus is
// issued and popped by a monitor on each accepted output beat. Build with
// +define+UART_STREAM_ARB_TIMEOUT_EN to exercise the stall watchdog.

module tb_uart_stream_arb;

  localparam int NSRC = 4;
  localparam int DW   = 8;

  logic            clk;
  logic            rst;
  logic [NSRC*DW-1:0] req_tdata;
  logic [NSRC-1:0] req_tvalid;
  logic [NSRC-1:0] req_tlast;
  logic [NSRC-1:0] req_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            pkt_done;
  logic            timeout_err;

  uart_stream_arb #(
    .DATA_WIDTH    (DW),
    .NUM_SRC       (NSRC),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_tdata    (req_tdata),
    .req_tvalid   (req_tvalid),
    .req_tlast    (req_tlast),
    .req_tready   (req_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .pkt_done     (pkt_done),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int src;
    int data;
    int gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src_mem [NSRC][32];
  int         rd [NSRC];
  int         wr [NSRC];
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] fire;

  int n_checks = 0;
  int n_fail   = 0;
  int pkt_cnt  = 0;
  int to_cnt   = 0;
  int ncyc     = 0;
  int last_beat = 0;
  logic       hold_vld = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_src();
    for (int i = 0; i < NSRC; i++) begin
      if (rd[i] != wr[i] && !mask[i]) begin
        req_tvalid[i]        = 1'b1;
        req_tdata[i*DW +: DW] = src_mem[i][rd[i]][7:0];
        req_tlast[i]         = src_mem[i][rd[i]][8];
      end else begin
        req_tvalid[i]        = 1'b0;
        req_tdata[i*DW +: DW] = '0;
        req_tlast[i]         = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int src, input int data, input logic last);
    src_mem[src][wr[src]] = {last, 8'(data)};
    wr[src]++;
  endtask

  task automatic exp_push(input int src, input int data, input int gap);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!grant_valid && n < 20);
    check("grant_wait", 32'(grant_valid), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    step();
    step();
  endtask

  // Source driver: retire a beat after each handshake, then present the next.
  initial begin
    forever begin
      @(negedge clk);
      fire = req_tvalid & req_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NSRC; i++) begin
        if (fire[i] && rd[i] != wr[i]) rd[i]++;
      end
      drive_src();
    end
  end

  // Output monitor: scoreboard compare, ready mirroring and stall stability.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (hold_vld && m_axis_tvalid) check("stall_data", 32'(m_axis_tdata), 32'(hold_data));
      hold_vld  = grant_valid && m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      check("req_tready", 32'(req_tready),
            grant_valid ? 32'(4'(m_axis_tready) << grant_id) : 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m_axis_tdata), 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat_data", 32'(m_axis_tdata), 32'(e.data));
          check("beat_src", 32'(grant_id), 32'(e.src));
          if (e.gap != 0) check("beat_gap", 32'(ncyc - last_beat), 32'(e.gap));
        end
        last_beat = ncyc;
      end
      if (pkt_done) pkt_cnt++;
      if (timeout_err) to_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    int pkt_snap;
    rst = 1'b1;
    m_axis_tready = 1'b0;
    mask = '0;
    req_tdata = '0;
    req_tvalid = '0;
    req_tlast = '0;
    for (int i = 0; i < NSRC; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end

    // Round robin over four single-beat packets, from reset priority.
    for (int i = 0; i < NSRC; i++) begin
      push_beat(i, 8'hA0 + i, 1'b1);
      exp_push(i, 8'hA0 + i, (i == 0) ? 0 : 2);
    end
    drive_src();
    step();
    step();
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_req_tready", 32'(req_tready), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    m_axis_tready = 1'b1;
    rst = 1'b0;
    wait_drain();
    check("rr_pkt_count", 32'(pkt_cnt), 32'd4);
    check("idle_grant_hold", 32'(grant_id), 32'd3);
    check("idle_grant_valid", 32'(grant_valid), 32'd0);

    // Packet lock: source 2 three beats while source 1 waits.
    m_axis_tready = 1'b0;
    push_beat(2, 8'h10, 1'b0);
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h12, 1'b1);
    exp_push(2, 8'h10, 0);
    exp_push(2, 8'h11, 1);
    exp_push(2, 8'h12, 1);
    drive_src();
    wait_grant();
    check("lock_first_grant", 32'(grant_id), 32'd2);
    push_beat(1, 8'h21, 1'b1);
    exp_push(1, 8'h21, 2);
    drive_src();
    m_axis_tready = 1'b1;
    wait_drain();

    // Backpressure 1,0,0,1 on a granted packet from source 0.
    m_axis_tready = 1'b0;
    push_beat(0, 8'h30, 1'b0);
    push_beat(0, 8'h31, 1'b0);
    push_beat(0, 8'h32, 1'b1);
    exp_push(0, 8'h30, 0);
    exp_push(0, 8'h31, 3);
    exp_push(0, 8'h32, 1);
    drive_src();
    wait_grant();
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    step();
    check("bp_stall_tdata", 32'(m_axis_tdata), 32'h31);
    step();
    m_axis_tready = 1'b1;
    wait_drain();

    // Reset after the second beat of a four-beat packet from source 3.
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) push_beat(3, 8'h40 + k, k == 3);
    exp_push(3, 8'h40, 0);
    exp_push(3, 8'h41, 1);
    drive_src();
    wait_grant();
    pkt_snap = pkt_cnt;
    step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("mid_rst_req_tready", 32'(req_tready), 32'd0);
    check("mid_rst_grant_valid", 32'(grant_valid), 32'd0);
    check("mid_rst_pkt_done", 32'(pkt_done), 32'd0);
    step();
    rd[3] = wr[3];
    push_beat(3, 8'h44, 1'b1);
    push_beat(0, 8'h50, 1'b1);
    exp_push(0, 8'h50, 0);
    exp_push(3, 8'h44, 2);
    drive_src();
    step();
    check("abort_no_pkt_done", 32'(pkt_cnt), 32'(pkt_snap));
    rst = 1'b0;
    wait_drain();

    // Source 1 stalls mid-packet for 8 cycles with source 2 waiting.
    m_axis_tready = 1'b1;
    push_beat(1, 8'h60, 1'b0);
    push_beat(1, 8'h61, 1'b0);
    push_beat(1, 8'h62, 1'b1);
    exp_push(1, 8'h60, 0);
`ifdef UART_STREAM_ARB_TIMEOUT_EN
    exp_push(2, 8'h70, 0);
    exp_push(1, 8'h61, 2);
    exp_push(1, 8'h62, 1);
`else
    exp_push(1, 8'h61, 0);
    exp_push(1, 8'h62, 1);
    exp_push(2, 8'h70, 2);
`endif
    drive_src();
    wait_grant();
    check("stall_grant", 32'(grant_id), 32'd1);
    step();
    mask[1] = 1'b1;
    push_beat(2, 8'h70, 1'b1);
    drive_src();
    for (int k = 1; k <= 8; k++) begin
`ifdef UART_STREAM_ARB_TIMEOUT_EN
      check("stall_timeout_err", 32'(timeout_err), 32'(k == 8));
`else
      check("stall_timeout_err", 32'(timeout_err), 32'd0);
`endif
      step();
    end
`ifdef UART_STREAM_ARB_TIMEOUT_EN
    check("to_idle", 32'(grant_valid), 32'd0);
    step();
    check("to_next_valid", 32'(grant_valid), 32'd1);
    check("to_next_grant", 32'(grant_id), 32'd2);
`else
    check("hold_grant_valid", 32'(grant_valid), 32'd1);
    check("hold_grant_id", 32'(grant_id), 32'd1);
    step();
    check("hold_grant_id_late", 32'(grant_id), 32'd1);
`endif
    mask[1] = 1'b0;
    drive_src();
    wait_drain();
`ifdef UART_STREAM_ARB_TIMEOUT_EN
    check("timeout_pulses", 32'(to_cnt), 32'd1);
`else
    check("timeout_pulses", 32'(to_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_stream_arb.md
UART_STREAM_ARB -- requirements
Module: uart_stream_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the byte width of every stream.
REQ-002 The block SHALL have parameter NUM_SRC, default 4, range 2..8, meaning the number of requester streams.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, range 2..65535, meaning the mid-packet stall limit.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, named as follows: clk  input  1  clock; rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have the port req_tdata  input  NUM_SRC*DATA_WIDTH  requester data, where source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 The block SHALL have the port req_tvalid  input  NUM_SRC  per-source valid.
REQ-007 The block SHALL have the port req_tlast  input  NUM_SRC  per-source end-of-packet marker.
REQ-008 The block SHALL have the port req_tready  output  NUM_SRC  per-source ready.
REQ-009 The block SHALL have the ports m_axis_tdata  output  DATA_WIDTH, m_axis_tvalid  output  1, and m_axis_tready  input  1, which together form the stream toward the UART transmitter s_axis.
REQ-010 The block SHALL have the port grant_valid  output  1, which is high while a packet is granted.
REQ-011 The block SHALL have the port grant_id  output  $clog2(NUM_SRC)  index of the granted source.
REQ-012 The block SHALL have the port pkt_done  output  1, a one-cycle pulse on acceptance of a tlast beat.
REQ-013 The block SHALL have the port timeout_err  output  1, a one-cycle pulse when a stalled grant is revoked.

Function
REQ-014 The state machine SHALL have the states IDLE and XFER; grant_valid SHALL equal (state==XFER).
REQ-015 In IDLE with any req_tvalid set, the block SHALL select the first set requester in round-robin order starting at last_grant+1 (mod NUM_SRC), register it into grant_id, and enter XFER on the next clock edge.
REQ-016 In IDLE, m_axis_tvalid and all req_tready bits SHALL be 0, giving one bubble cycle per arbitration.
REQ-017 In XFER, the datapath SHALL be combinational: m_axis_tdata=req_tdata[grant_id], m_axis_tvalid=req_tvalid[grant_id], req_tready[grant_id]=m_axis_tready, and all other req_tready bits SHALL be 0.
REQ-018 A beat SHALL transfer only when m_axis_tvalid and m_axis_tready are both high, and no data SHALL be buffered, dropped or duplicated.
REQ-019 On a transferred beat with req_tlast[grant_id]=1, the block SHALL pulse pkt_done, set last_grant=grant_id, and return to IDLE.
REQ-020 The grant SHALL be packet-locked: valid deassertion by other sources, or a new valid from other sources, SHALL NOT change grant_id while in XFER.
REQ-021 A single-beat packet (tlast on the first beat) SHALL occupy exactly one XFER cycle when m_axis_tready=1.
REQ-022 A source whose valid drops while it is waiting in IDLE SHALL simply not be selected, and no request state SHALL be latched.
REQ-023 grant_id SHALL hold its last value while in IDLE.

Reset
REQ-024 On rst, the block SHALL immediately set state=IDLE, grant_id=0, last_grant=NUM_SRC-1 (so source 0 has first priority), stall counter=0, and pkt_done=0, timeout_err=0, grant_valid=0, m_axis_tvalid=0, req_tready=0.
REQ-025 Reset asserted mid-packet SHALL abandon the packet with no pkt_done pulse, and after reset the first arbitration SHALL follow REQ-024 priority.

Configuration
REQ-026 The macro UART_STREAM_ARB_TIMEOUT_EN SHALL compile in the stall watchdog.
REQ-027 With the watchdog compiled in, a counter SHALL increment each XFER cycle with req_tvalid[grant_id]=0, clear on any cycle with valid high and on entry to XFER, and on reaching TIMEOUT_CYCLES the block SHALL pulse timeout_err, set last_grant=grant_id and return to IDLE.
REQ-028 A cycle with valid high but m_axis_tready low SHALL NOT count toward the timeout.
REQ-029 Without the macro, no counter SHALL exist, timeout_err SHALL be tied 0, and a stalled grant SHALL be held indefinitely.

Verification
REQ-030 The bench SHALL cover this case: after reset, sources 0..3 all valid with 1-beat packets 0xA0..0xA3 and tready=1 -> output order A0,A1,A2,A3, each preceded by one idle cycle, with 4 pkt_done pulses.
REQ-031 The bench SHALL cover this case: source 2 sends a 3-beat packet 0x10,0x11,0x12 while source 1 is valid -> all three bytes are output contiguously with grant_id=2, and then source 1 is granted.
REQ-032 The bench SHALL cover this case: m_axis_tready toggles 1,0,0,1 during a granted packet -> m_axis_tdata stays stable while stalled, no beat is lost, and req_tready mirrors m_axis_tready.
REQ-033 The bench SHALL cover this case: rst is asserted after the 2nd beat of a 4-beat packet from source 3 -> outputs are zero immediately, with no pkt_done; after release, source 0 wins if valid.
REQ-034 With the macro defined and TIMEOUT_CYCLES=8, the bench SHALL cover this case: source 1 drops valid mid-packet for 8 cycles -> timeout_err pulses once, the state returns to IDLE, and source 2 is granted next.
REQ-035 Without the macro, the bench SHALL cover the REQ-034 stimulus -> grant_id stays 1 and timeout_err stays 0.
